param_branch_predictor: RTL and testbench
=========================================

PARAM_BRANCH_PREDICTOR -- requirements
Module: param_branch_predictor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning PC/target width.
REQ-002 SHALL have parameter BTB_IDX_SIZE, default 8, meaning index bits; DEPTH = 2**BTB_IDX_SIZE entries.
REQ-003 SHALL have parameter MODE, default 2, meaning 0 never-taken, 1 BTB-hit-taken, 2 2-bit saturating, 3 2-bit hysteresis.
REQ-004 SHALL have clk  in  1  sole clock, rising edge; one clock; reset is synchronous and active-low.
REQ-005 SHALL have reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have pc_if  in  WORD_SIZE  PC being fetched.
REQ-007 SHALL have predicted_pc_if  out  WORD_SIZE  predicted next PC, combinational from pc_if.
REQ-008 SHALL have tag_match_if  out  1  valid BTB hit for pc_if.
REQ-009 SHALL have update_tag  in  1  install or overwrite BTB entry.
REQ-010 SHALL have update_pc, update_target  in  WORD_SIZE each  branch PC and its resolved target.
REQ-011 SHALL have update_bht  in  1  resolved-branch strobe; bht_pc  in  WORD_SIZE; bht_taken  in  1  actual outcome; bht_miss  in  1  prediction was wrong.
REQ-012 SHALL have inv_req  in  1  start invalidation sweep; busy  out  1  sweep in progress.
REQ-013 SHALL have num_branch, num_branch_miss  out  WORD_SIZE each  statistics.

Function
REQ-014 SHALL use index = pc[BTB_IDX_SIZE-1:0] and tag = pc[WORD_SIZE-1:BTB_IDX_SIZE]; each entry holds valid, tag, target and a 2-bit counter.
REQ-015 SHALL assert tag_match_if when the indexed entry is valid, tags are equal and busy=0.
REQ-016 SHALL drive predicted_pc_if = target when hit and predict-taken, else pc_if+1 modulo 2**WORD_SIZE (0xFFFF wraps to 0x0000).
REQ-017 SHALL define predict-taken as: MODE 0 never; MODE 1 always on hit; MODES 2/3 counter[1].
REQ-018 SHALL use counter encoding 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
REQ-019 SHALL, in MODE 2, increment the counter on taken (saturate at 3) and decrement on not-taken (saturate at 0).
REQ-020 SHALL, in MODE 3, apply MODE 2 rules except 1+taken->3 and 2+not-taken->0.
REQ-021 SHALL, on update_tag, write valid=1, tag, target and counter=2 at the next edge.
REQ-022 SHALL, on update_bht with a valid tag hit for bht_pc, write the next counter value at the next edge; on a miss, leave the entry unchanged.
REQ-023 SHALL, when update_tag and update_bht hit the same index in one cycle, apply update_tag only; different indices SHALL both be applied.
REQ-024 SHALL increment num_branch on every update_bht and num_branch_miss on update_bht with bht_miss=1; both SHALL saturate at all-ones; both SHALL count while busy.
REQ-025 SHALL, on inv_req while IDLE, enter SWEEP and assert busy from the next cycle.
REQ-026 SHALL, in SWEEP, clear valid for one index per cycle from 0 to DEPTH-1, holding busy for exactly DEPTH cycles, then return to IDLE.
REQ-027 SHALL ignore inv_req while busy, and SHALL ignore update_tag and BTB/counter updates while busy.

Reset
REQ-028 SHALL, on reset_n=0 at an edge, clear all valid bits, set all counters to 0, set state IDLE, and set busy=0, num_branch=0 and num_branch_miss=0.
REQ-029 SHALL give reset priority over all inputs and SHALL abort a sweep in progress.
REQ-030 SHALL drive predicted_pc_if = pc_if+1 and tag_match_if=0 while in reset.

Structure
REQ-031 SHALL place MODE encodings, counter encodings and sweep-state encodings in the shared constants file.
REQ-032 SHALL implement the 2-bit next-counter function as a combinational sub-module, bp_counter_next (inputs MODE, counter, taken).

Verification
REQ-033 SHALL test, after reset, pc_if=0x0010: predicted_pc_if=0x0011, tag_match_if=0, pc_if=0xFFFF -> 0x0000.
REQ-034 SHALL test MODE 2 update_tag pc 0x0010 target 0x0040: next cycle hit, predicted 0x0040; two not-taken bht -> predicted 0x0011.
REQ-035 SHALL test MODE 3: counter 2 + not-taken -> 0 (predict 0x0011); taken -> 1; taken -> 3.
REQ-036 SHALL test an alias: entry at 0x0010, lookup 0x0110 (index 0x10, different tag): tag_match_if=0, predicted 0x0111.
REQ-037 SHALL test inv_req with BTB_IDX_SIZE=2: busy high exactly 4 cycles, updates and inv_req ignored during the sweep, all entries miss afterwards; reset_n=0 mid-sweep -> busy=0 next cycle.
REQ-038 SHALL test counter saturation: preload num_branch_miss to 0xFFFF, then update_bht with bht_miss=1 -> stays 0xFFFF.

Source files
------------

// File: rtl/param_branch_predictor_pkg.sv
// Shared constants for the parameterised branch predictor: predictor modes,
// 2-bit counter encodings and invalidation-sweep state encodings.
package param_branch_predictor_pkg;

    // Prediction policy selected by the MODE parameter
    localparam int MODE_NEVER   = 0;  // always predict fall-through
    localparam int MODE_BTB_HIT = 1;  // predict taken on any valid BTB hit
    localparam int MODE_SAT2    = 2;  // 2-bit saturating counter
    localparam int MODE_HYST2   = 3;  // 2-bit counter with hysteresis jumps

    // 2-bit direction counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'd0,
        CTR_WEAK_NT   = 2'd1,
        CTR_WEAK_T    = 2'd2,
        CTR_STRONG_T  = 2'd3
    } ctr_e;

    // Invalidation sweep controller states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/param_branch_predictor_counter_next.sv
// Combinational next-value function for the 2-bit branch direction counter.
// MODE_HYST2 jumps straight to the strong state when a weak prediction is
// contradicted; every other mode uses plain saturating up/down counting.
module bp_counter_next
    import param_branch_predictor_pkg::*;
#(
    parameter int MODE = MODE_SAT2
) (
    input  logic [1:0] counter,
    input  logic       taken,
    output logic [1:0] counter_next
);

    // Saturating increment/decrement with optional hysteresis jumps
    always_comb begin
        counter_next = counter;
        if (taken) begin
            if ((MODE == MODE_HYST2) && (counter == CTR_WEAK_NT)) begin
                counter_next = CTR_STRONG_T;
            end else if (counter != CTR_STRONG_T) begin
                counter_next = counter + 2'd1;
            end
        end else begin
            if ((MODE == MODE_HYST2) && (counter == CTR_WEAK_T)) begin
                counter_next = CTR_STRONG_NT;
            end else if (counter != CTR_STRONG_NT) begin
                counter_next = counter - 2'd1;
            end
        end
    end

endmodule

// File: rtl/param_branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters, a one-index-per-
// cycle invalidation sweep and saturating branch/mispredict statistics.
// Lookup is combinational from pc_if so the fetch stage sees the prediction
// in the same cycle; storage is therefore register-based, not block RAM.
module param_branch_predictor
    import param_branch_predictor_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_SIZE = 8,
    parameter int MODE         = MODE_SAT2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc_if,
    output logic [WORD_SIZE-1:0] predicted_pc_if,
    output logic                 tag_match_if,
    input  logic                 update_tag,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_bht,
    input  logic [WORD_SIZE-1:0] bht_pc,
    input  logic                 bht_taken,
    input  logic                 bht_miss,
    input  logic                 inv_req,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] num_branch,
    output logic [WORD_SIZE-1:0] num_branch_miss
);

    localparam int DEPTH = 2 ** BTB_IDX_SIZE;
    localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;

    // BTB storage
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q    [DEPTH];
    logic [TAG_W-1:0]     tag_d    [DEPTH];
    logic [WORD_SIZE-1:0] target_q [DEPTH];
    logic [WORD_SIZE-1:0] target_d [DEPTH];
    logic [1:0]           ctr_q    [DEPTH];
    logic [1:0]           ctr_d    [DEPTH];

    // Sweep controller and statistics
    sweep_state_e          state_q, state_d;
    logic [BTB_IDX_SIZE-1:0] sweep_idx_q, sweep_idx_d;
    logic [WORD_SIZE-1:0]  num_branch_q, num_branch_d;
    logic [WORD_SIZE-1:0]  num_branch_miss_q, num_branch_miss_d;

    // Address split for the three access ports
    logic [BTB_IDX_SIZE-1:0] idx_if, upd_idx, bht_idx;
    logic [TAG_W-1:0]        tag_if, upd_tag, bht_tag;

    assign idx_if  = pc_if[BTB_IDX_SIZE-1:0];
    assign tag_if  = pc_if[WORD_SIZE-1:BTB_IDX_SIZE];
    assign upd_idx = update_pc[BTB_IDX_SIZE-1:0];
    assign upd_tag = update_pc[WORD_SIZE-1:BTB_IDX_SIZE];
    assign bht_idx = bht_pc[BTB_IDX_SIZE-1:0];
    assign bht_tag = bht_pc[WORD_SIZE-1:BTB_IDX_SIZE];

    assign busy = (state_q == ST_SWEEP);

    // Fetch-side lookup and next-PC selection; forced to fall-through in reset
    logic taken_if;
    always_comb begin
        tag_match_if = reset_n && !busy && valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        if (MODE == MODE_NEVER) begin
            taken_if = 1'b0;
        end else if (MODE == MODE_BTB_HIT) begin
            taken_if = 1'b1;
        end else begin
            taken_if = ctr_q[idx_if][1];
        end
        predicted_pc_if = (tag_match_if && taken_if) ? target_q[idx_if]
                                                     : pc_if + WORD_SIZE'(1);
    end

    // Resolved-branch counter update goes only to entries that really hit
    logic       bht_hit;
    logic [1:0] bht_ctr_next;
    logic       tag_wr, bht_wr;

    assign bht_hit = valid_q[bht_idx] && (tag_q[bht_idx] == bht_tag);
    assign tag_wr  = update_tag && !busy;
    // An install to the same index wins over a counter update
    assign bht_wr  = update_bht && !busy && bht_hit && !(tag_wr && (upd_idx == bht_idx));

    bp_counter_next #(
        .MODE (MODE)
    ) u_counter_next (
        .counter      (ctr_q[bht_idx]),
        .taken        (bht_taken),
        .counter_next (bht_ctr_next)
    );

    // Per-entry write-enable decode
    logic [DEPTH-1:0] tag_we, bht_we, clr_we;
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign tag_we[gi] = tag_wr && (upd_idx == BTB_IDX_SIZE'(gi));
            assign bht_we[gi] = bht_wr && (bht_idx == BTB_IDX_SIZE'(gi));
            assign clr_we[gi] = busy && (sweep_idx_q == BTB_IDX_SIZE'(gi));
        end
    endgenerate

    // Next-state of every BTB entry
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_we[i]) begin
                valid_d[i] = 1'b0;
            end
            if (tag_we[i]) begin
                valid_d[i]  = 1'b1;
                tag_d[i]    = upd_tag;
                target_d[i] = update_target;
                ctr_d[i]    = CTR_WEAK_T;
            end else if (bht_we[i]) begin
                ctr_d[i] = bht_ctr_next;
            end
        end
    end

    // Sweep FSM: one index per cycle, returns to idle after the last index
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_req) begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                end
            end
            ST_SWEEP: begin
                sweep_idx_d = sweep_idx_q + BTB_IDX_SIZE'(1);
                if (&sweep_idx_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating statistics, counted regardless of sweep activity
    always_comb begin
        num_branch_d      = num_branch_q;
        num_branch_miss_d = num_branch_miss_q;
        if (update_bht) begin
            if (!(&num_branch_q)) begin
                num_branch_d = num_branch_q + WORD_SIZE'(1);
            end
            if (bht_miss && !(&num_branch_miss_q)) begin
                num_branch_miss_d = num_branch_miss_q + WORD_SIZE'(1);
            end
        end
    end

    // Control state, valid bits and counters: reset wins over everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q           <= '0;
            ctr_q             <= '{default: 2'd0};
            state_q           <= ST_IDLE;
            sweep_idx_q       <= '0;
            num_branch_q      <= '0;
            num_branch_miss_q <= '0;
        end else begin
            valid_q           <= valid_d;
            ctr_q             <= ctr_d;
            state_q           <= state_d;
            sweep_idx_q       <= sweep_idx_d;
            num_branch_q      <= num_branch_d;
            num_branch_miss_q <= num_branch_miss_d;
        end
    end

    // Tag and target payload: meaningless until valid, so no reset needed
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign num_branch      = num_branch_q;
    assign num_branch_miss = num_branch_miss_q;

endmodule

// File: tb/tb_param_branch_predictor.sv
// Bench for param_branch_predictor: three instances (MODE 2, MODE 3, and a
// 4-entry MODE 2 for the sweep) share one stimulus. A vector table drives
// the prediction/update behaviour through a scoreboard queue; hand-written
// sequences cover the sweep, reset abort and statistics saturation.
module tb_param_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc_if;
    logic        update_tag;
    logic [15:0] update_pc, update_target;
    logic        update_bht;
    logic [15:0] bht_pc;
    logic        bht_taken, bht_miss, inv_req;

    logic [15:0] pred2, pred3, preds;
    logic        hit2, hit3, hits;
    logic        busy2, busy3, busys;
    logic [15:0] nb2, nbm2, nb3, nbm3, nbs, nbms;

    always #5 clk = ~clk;

    param_branch_predictor #(.WORD_SIZE(16), .BTB_IDX_SIZE(8), .MODE(2)) u_m2 (
        .clk(clk), .reset_n(reset_n), .pc_if(pc_if), .predicted_pc_if(pred2),
        .tag_match_if(hit2), .update_tag(update_tag), .update_pc(update_pc),
        .update_target(update_target), .update_bht(update_bht), .bht_pc(bht_pc),
        .bht_taken(bht_taken), .bht_miss(bht_miss), .inv_req(inv_req),
        .busy(busy2), .num_branch(nb2), .num_branch_miss(nbm2)
    );

    param_branch_predictor #(.WORD_SIZE(16), .BTB_IDX_SIZE(8), .MODE(3)) u_m3 (
        .clk(clk), .reset_n(reset_n), .pc_if(pc_if), .predicted_pc_if(pred3),
        .tag_match_if(hit3), .update_tag(update_tag), .update_pc(update_pc),
        .update_target(update_target), .update_bht(update_bht), .bht_pc(bht_pc),
        .bht_taken(bht_taken), .bht_miss(bht_miss), .inv_req(inv_req),
        .busy(busy3), .num_branch(nb3), .num_branch_miss(nbm3)
    );

    param_branch_predictor #(.WORD_SIZE(16), .BTB_IDX_SIZE(2), .MODE(2)) u_s (
        .clk(clk), .reset_n(reset_n), .pc_if(pc_if), .predicted_pc_if(preds),
        .tag_match_if(hits), .update_tag(update_tag), .update_pc(update_pc),
        .update_target(update_target), .update_bht(update_bht), .bht_pc(bht_pc),
        .bht_taken(bht_taken), .bht_miss(bht_miss), .inv_req(inv_req),
        .busy(busys), .num_branch(nbs), .num_branch_miss(nbms)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic        ut;
        logic [15:0] upc;
        logic [15:0] utgt;
        logic        ub;
        logic [15:0] bpc;
        logic        bt;
        logic        bm;
        logic [15:0] ep2;
        logic        eh2;
        logic [15:0] ep3;
        logic        eh3;
    } vec_t;

    typedef struct packed {
        logic [15:0] p2;
        logic        h2;
        logic [15:0] p3;
        logic        h3;
        logic [15:0] nb;
        logic [15:0] nbm;
    } exp_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_nb, model_nbm;
    int busy_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        update_tag    = 1'b0;
        update_pc     = 16'h0000;
        update_target = 16'h0000;
        update_bht    = 1'b0;
        bht_pc        = 16'h0000;
        bht_taken     = 1'b0;
        bht_miss      = 1'b0;
        inv_req       = 1'b0;
    endtask

    initial begin
        //             pc       ut    upc       utgt      ub    bpc       bt    bm    ep2       eh2   ep3       eh3
        vecs[0]  = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0011, 1'b0, 16'h0011, 1'b0};
        vecs[1]  = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{16'h0010, 1'b1, 16'h0010, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0011, 1'b0, 16'h0011, 1'b0};
        vecs[3]  = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1};
        vecs[4]  = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b1};
        vecs[5]  = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b1};
        vecs[6]  = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b1};
        vecs[7]  = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1};
        vecs[8]  = '{16'h0110, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0110, 1'b1, 1'b0, 16'h0111, 1'b0, 16'h0111, 1'b0};
        vecs[9]  = '{16'h0010, 1'b1, 16'h0010, 16'h0050, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0011, 1'b1, 16'h0040, 1'b1};
        vecs[10] = '{16'h0010, 1'b1, 16'h0020, 16'h0080, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0050, 1'b1, 16'h0050, 1'b1};
        vecs[11] = '{16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0080, 1'b1, 16'h0080, 1'b1};
        vecs[12] = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0050, 1'b1, 16'h0050, 1'b1};
        vecs[13] = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b1};
        vecs[14] = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0011, 1'b1, 16'h0011, 1'b1};
        vecs[15] = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0050, 1'b1, 16'h0011, 1'b1};
        vecs[16] = '{16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0050, 1'b1, 16'h0050, 1'b1};

        // Reset
        reset_n = 1'b0;
        pc_if   = 16'h0010;
        idle_inputs();
        repeat (3) @(negedge clk);
        #2;
        chk("in_reset_hit2", {31'd0, hit2}, 32'd0);
        chk("in_reset_pred2", {16'd0, pred2}, 32'h0011);
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_nb2", {16'd0, nb2}, 32'd0);
        chk("rst_nbm2", {16'd0, nbm2}, 32'd0);

        // Table-driven transactions through the scoreboard
        model_nb  = 16'h0000;
        model_nbm = 16'h0000;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            pc_if         = vecs[i].pc;
            update_tag    = vecs[i].ut;
            update_pc     = vecs[i].upc;
            update_target = vecs[i].utgt;
            update_bht    = vecs[i].ub;
            bht_pc        = vecs[i].bpc;
            bht_taken     = vecs[i].bt;
            bht_miss      = vecs[i].bm;
            sb_q.push_back('{vecs[i].ep2, vecs[i].eh2, vecs[i].ep3, vecs[i].eh3, model_nb, model_nbm});
            #2;
            e = sb_q.pop_front();
            $display("txn %0d pc=%h pred2=%h hit2=%b pred3=%h hit3=%b nb=%0d nbm=%0d",
                     i, pc_if, pred2, hit2, pred3, hit3, nb2, nbm2);
            chk($sformatf("v%0d_pred2", i), {16'd0, pred2}, {16'd0, e.p2});
            chk($sformatf("v%0d_hit2", i), {31'd0, hit2}, {31'd0, e.h2});
            chk($sformatf("v%0d_pred3", i), {16'd0, pred3}, {16'd0, e.p3});
            chk($sformatf("v%0d_hit3", i), {31'd0, hit3}, {31'd0, e.h3});
            chk($sformatf("v%0d_nb", i), {16'd0, nb2}, {16'd0, e.nb});
            chk($sformatf("v%0d_nbm", i), {16'd0, nbm2}, {16'd0, e.nbm});
            if (vecs[i].ub) model_nb = model_nb + 16'd1;
            if (vecs[i].ub && vecs[i].bm) model_nbm = model_nbm + 16'd1;
        end
        @(negedge clk);
        idle_inputs();
        #2;
        chk("table_nb_final", {16'd0, nb2}, {16'd0, model_nb});
        chk("table_nbm_final", {16'd0, nbm2}, {16'd0, model_nbm});

        // Fill all four entries of the small instance
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            update_tag    = 1'b1;
            update_pc     = 16'(i);
            update_target = 16'h0100 + 16'(i);
        end
        @(negedge clk);
        update_tag = 1'b0;
        pc_if      = 16'h0002;
        #2;
        $display("txn fill pc=%h preds=%h hits=%b", pc_if, preds, hits);
        chk("fill_hit_s", {31'd0, hits}, 32'd1);
        chk("fill_pred_s", {16'd0, preds}, 32'h0102);

        // Sweep: busy for exactly DEPTH cycles, inputs ignored meanwhile
        @(negedge clk);
        inv_req = 1'b1;
        #2;
        chk("sweep_busy_before", {31'd0, busys}, 32'd0);
        @(negedge clk);
        update_tag    = 1'b1;
        update_pc     = 16'h0001;
        update_target = 16'h0999;
        #2;
        busy_cnt = 0;
        while (busys && busy_cnt < 20) begin
            chk($sformatf("sweep_hit_c%0d", busy_cnt), {31'd0, hits}, 32'd0);
            busy_cnt++;
            @(negedge clk);
            if (busy_cnt >= 2) inv_req = 1'b0;
            #2;
        end
        update_tag = 1'b0;
        inv_req    = 1'b0;
        $display("txn sweep busy_cycles=%0d", busy_cnt);
        chk("sweep_busy_cycles", busy_cnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pc_if = 16'(i);
            #2;
            $display("txn post_sweep pc=%h preds=%h hits=%b busy=%b", pc_if, preds, hits, busys);
            chk($sformatf("post_sweep_hit%0d", i), {31'd0, hits}, 32'd0);
            chk($sformatf("post_sweep_pred%0d", i), {16'd0, preds}, 32'(i + 1));
            chk($sformatf("post_sweep_busy%0d", i), {31'd0, busys}, 32'd0);
        end

        // Reset in the middle of a sweep
        @(negedge clk);
        inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        #2;
        chk("abort_busy_pre", {31'd0, busys}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        pc_if   = 16'h0010;
        @(negedge clk);
        #2;
        $display("txn abort busys=%b busy2=%b hit2=%b pred2=%h", busys, busy2, hit2, pred2);
        chk("abort_busy_s", {31'd0, busys}, 32'd0);
        chk("abort_busy2", {31'd0, busy2}, 32'd0);
        chk("abort_busy3", {31'd0, busy3}, 32'd0);
        chk("abort_pred2", {16'd0, pred2}, 32'h0011);
        chk("abort_nb2", {16'd0, nb2}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        chk("post_reset_hit2", {31'd0, hit2}, 32'd0);
        chk("post_reset_pred3", {16'd0, pred3}, 32'h0011);

        // Statistics saturation
        @(negedge clk);
        update_bht = 1'b1;
        bht_miss   = 1'b1;
        bht_pc     = 16'h1234;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_nbm_fffe", {16'd0, nbm2}, 32'hFFFE);
        @(posedge clk);
        #1;
        chk("sat_nbm_ffff", {16'd0, nbm2}, 32'hFFFF);
        @(posedge clk);
        #1;
        $display("txn saturate nb=%h nbm=%h", nb2, nbm2);
        chk("sat_nbm_hold", {16'd0, nbm2}, 32'hFFFF);
        chk("sat_nb_hold", {16'd0, nb2}, 32'hFFFF);
        @(negedge clk);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
